fft_input_loader: RTL and testbench
===================================

Name: fft_input_loader

Overview:
Front-end feeder for the radix-4 SDF FFT top (fft_top). Accepts one complex sample per cycle in natural time order over a valid/ready stream. Each sample is stored at its base-4 digit-reversed address in a ping-pong frame buffer. Completed frames are replayed as contiguous 4-lane bursts that drive fft_top's input_en and input_real_k/input_imag_k directly, so software and host no longer pre-reverse input data.

Parameters:
WIDTH, 16, sample component width (two's complement)
Num_of_samples, 256, FFT length N; legal values 16, 64, 256 (a power of 4)
LOG4N, derived, log4(N), number of base-4 digits in a sample index

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
s_valid  in  1  serial sample valid
s_ready  out  1  loader can accept a sample
s_real  in  WIDTH  sample real part
s_imag  in  WIDTH  sample imaginary part
s_last  in  1  marks the last sample of a frame; checked only, not required
fft_ready  in  1  downstream permits the start of a frame burst
input_en  out  1  burst valid, to fft_top
input_real_0..3  out  WIDTH each  lane k real part, to fft_top
input_imag_0..3  out  WIDTH each  lane k imaginary part, to fft_top
frame_err  out  1  sticky: s_last/frame-length mismatch

Behaviour:
- Reset (reset==0 at a clock edge):
  - input_en=0; all lane outputs=0; s_ready=0 while in reset; frame_err=0.
  - Both banks marked empty; write index=0; fill bank=0; drain FSM=IDLE.
  - Reset mid-frame or mid-burst discards all buffered data. The first cycle after reset is released, s_ready=1.
- Storage:
  - Two banks of N entries each.
  - Each bank is split into 4 lane memories of N/4 rows.
  - Reversed address a=rev4(n), where rev4 reverses the LOG4N base-4 digits of n. The sample goes to lane a[1:0], row a>>2.
- Write side:
  - A transfer happens when s_valid&&s_ready.
  - The write index n counts 0..N-1, then wraps to 0. At that point the fill bank is marked full and the fill bank toggles.
  - s_ready = !full[fill_bank].
- Frame checking:
  - s_last with n!=N-1 sets frame_err.
  - n==N-1 without s_last also sets frame_err.
  - The index is never resynchronised by s_last.
- Drain FSM:
  - IDLE -> BURST when full[drain_bank] && fft_ready.
  - BURST issues row reads c=0..N/4-1 on consecutive cycles. fft_ready is ignored once a burst has started; a burst is never interrupted.
  - After row N/4-1 is issued: clear full[drain_bank], toggle drain_bank, return to IDLE.
  - If the next bank is already full and fft_ready=1, go back to BURST on the following cycle with a one-cycle gap.
- Read timing:
  - Reads are registered. input_en and lane data appear 1 cycle after the row is issued.
  - Lane k in burst cycle c carries x[n] with rev4(n)=4c+k.
- Latency:
  - Last sample accepted at cycle t with the drain bank idle and fft_ready=1: IDLE->BURST at t+1, input_en first high at t+2.
  - input_en stays high for exactly N/4 consecutive cycles.
- Simultaneous events:
  - A fill completion and a drain release in the same cycle both update their own bank flags. No lost state.
  - A freed bank makes s_ready high on the next cycle.
- Throughput:
  - Sustained 1 sample/cycle in, 4 samples/cycle out.
  - s_ready deasserts only when both banks are full.
- Outputs hold their last values when input_en=0. Consumers ignore data while input_en=0.

Decomposition:
- Shared package fft_pkg: WIDTH and N legality constants, LOG4N function, rev4 function (also used by the output-side reorder).
- One sub-module: fft_lane_ram, a simple dual-port memory of N/4 x 2*WIDTH with a registered read. Instantiate 4 lanes x 2 banks, or 4 instances with the bank folded into the address MSB.

Test Plan:
1. N=16, x[n]=n+0j streamed back-to-back -> 4 bursts with lanes (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15). input_en is high for exactly 4 cycles, first at t+2 after the last accept.
2. N=256 ramp -> burst cycle 0 lanes (0,64,128,192), cycle 1 (16,80,144,208); 64 contiguous input_en cycles; imaginary lanes carry s_imag unchanged.
3. fft_ready=0 while 3 frames are sent -> 2 frames accepted, then s_ready=0. Raising fft_ready -> two bursts separated by exactly 1 idle cycle, then s_ready=1.
4. fft_ready dropped mid-burst -> burst completes all N/4 cycles unchanged.
5. s_last asserted at n=10 (N=16) -> frame_err=1 and sticky. Also check the reverse case: s_last missing at n=N-1 -> frame_err=1.
6. reset=0 asserted mid-fill and mid-burst -> next cycle input_en=0 and all outputs 0. After release, a fresh 16-sample ramp reproduces scenario 1 exactly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT constants and index helpers: legal lengths, log4(N), and base-4 digit reversal.
package fft_pkg;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned N_DEF     = 256;
   localparam int unsigned N_MIN     = 16;
   localparam int unsigned N_MAX     = 256;

   function automatic bit n_is_legal(input int unsigned n);
      return (n == 16) || (n == 64) || (n == 256);
   endfunction

   function automatic int unsigned log4n(input int unsigned n);
      int unsigned d;
      d = 0;
      for (int unsigned v = n; v > 1; v = v >> 2) d++;
      return d;
   endfunction

   // Reverses the low 'digits' base-4 digits of idx; the lowest digit becomes the highest.
   function automatic logic [15:0] rev4(input logic [15:0] idx, input int unsigned digits);
      logic [15:0] v;
      logic [15:0] r;
      v = idx;
      r = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < digits) begin
            r = {r[13:0], v[1:0]};
            v = v >> 2;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_lane_ram.sv
// Simple dual-port lane memory with a registered, resettable read port.
module fft_lane_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read data holds its value between bursts; reset clears it.
   always_ff @(posedge clock) begin
      if (!reset)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fft_input_loader.sv
// Serial-to-4-lane FFT feeder: stores samples digit-reversed into a ping-pong buffer
// and replays each completed frame as a contiguous burst of N/4 rows.
module fft_input_loader
   import fft_pkg::*;
#(
   parameter int unsigned WIDTH          = WIDTH_DEF,
   parameter int unsigned Num_of_samples = N_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_real,
   input  logic [WIDTH-1:0] s_imag,
   input  logic             s_last,
   input  logic             fft_ready,
   output logic             input_en,
   output logic [WIDTH-1:0] input_real_0,
   output logic [WIDTH-1:0] input_real_1,
   output logic [WIDTH-1:0] input_real_2,
   output logic [WIDTH-1:0] input_real_3,
   output logic [WIDTH-1:0] input_imag_0,
   output logic [WIDTH-1:0] input_imag_1,
   output logic [WIDTH-1:0] input_imag_2,
   output logic [WIDTH-1:0] input_imag_3,
   output logic             frame_err
);

   localparam int unsigned LOG4N  = log4n(Num_of_samples);
   localparam int unsigned IDX_W  = 2 * LOG4N;
   localparam int unsigned ROW_W  = IDX_W - 2;
   localparam int unsigned ROWS   = Num_of_samples / 4;
   localparam int unsigned DATA_W = 2 * WIDTH;
   localparam int unsigned ADDR_W = ROW_W + 1;

   if (!n_is_legal(Num_of_samples)) begin : g_bad_n
      $error("fft_input_loader: Num_of_samples must be 16, 64 or 256");
   end

   typedef enum logic {DRAIN_IDLE, DRAIN_BURST} drain_state_t;

   drain_state_t               state;
   logic [IDX_W-1:0]           wr_idx;
   logic [ROW_W-1:0]           rd_row;
   logic [1:0]                 full;
   logic                       fill_bank;
   logic                       drain_bank;
   logic [3:0][DATA_W-1:0]     rd_data;

   logic                       accept_c;
   logic                       fill_done_c;
   logic                       drain_done_c;
   logic                       start_c;
   logic                       fill_bank_nxt_c;
   logic [1:0]                 full_nxt_c;
   logic [IDX_W-1:0]           rev_addr_c;

   // Bank bookkeeping; a fill into the drain bank can start a burst on the same edge.
   always_comb begin
      accept_c        = s_valid && s_ready;
      fill_done_c     = accept_c && (wr_idx == IDX_W'(Num_of_samples - 1));
      drain_done_c    = (state == DRAIN_BURST) && (rd_row == ROW_W'(ROWS - 1));
      rev_addr_c      = IDX_W'(rev4(16'(wr_idx), LOG4N));
      fill_bank_nxt_c = fill_bank ^ fill_done_c;
      full_nxt_c      = full;
      if (drain_done_c) full_nxt_c[drain_bank] = 1'b0;
      if (fill_done_c)  full_nxt_c[fill_bank]  = 1'b1;
      start_c = (state == DRAIN_IDLE) && fft_ready &&
                (full[drain_bank] || (fill_done_c && (fill_bank == drain_bank)));
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= DRAIN_IDLE;
         wr_idx     <= '0;
         rd_row     <= '0;
         full       <= '0;
         fill_bank  <= 1'b0;
         drain_bank <= 1'b0;
         s_ready    <= 1'b0;
         input_en   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         full      <= full_nxt_c;
         fill_bank <= fill_bank_nxt_c;
         s_ready   <= !full_nxt_c[fill_bank_nxt_c];
         input_en  <= (state == DRAIN_BURST);
         if (accept_c) begin
            wr_idx <= wr_idx + IDX_W'(1);
            if (s_last != fill_done_c) frame_err <= 1'b1;
         end
         case (state)
            DRAIN_IDLE: begin
               if (start_c) begin
                  state  <= DRAIN_BURST;
                  rd_row <= '0;
               end
            end
            DRAIN_BURST: begin
               rd_row <= rd_row + ROW_W'(1);
               if (drain_done_c) begin
                  state      <= DRAIN_IDLE;
                  drain_bank <= !drain_bank;
               end
            end
            default: state <= DRAIN_IDLE;
         endcase
      end
   end

   // Bank is folded into the address MSB of each lane memory.
   for (genvar k = 0; k < 4; k++) begin : g_lane
      fft_lane_ram #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_lane_ram (
         .clock   (clock),
         .reset   (reset),
         .wr_en   (accept_c && (rev_addr_c[1:0] == 2'(k))),
         .wr_addr ({fill_bank, rev_addr_c[IDX_W-1:2]}),
         .wr_data ({s_real, s_imag}),
         .rd_en   (state == DRAIN_BURST),
         .rd_addr ({drain_bank, rd_row}),
         .rd_data (rd_data[k])
      );
   end

   assign input_real_0 = rd_data[0][DATA_W-1:WIDTH];
   assign input_real_1 = rd_data[1][DATA_W-1:WIDTH];
   assign input_real_2 = rd_data[2][DATA_W-1:WIDTH];
   assign input_real_3 = rd_data[3][DATA_W-1:WIDTH];
   assign input_imag_0 = rd_data[0][WIDTH-1:0];
   assign input_imag_1 = rd_data[1][WIDTH-1:0];
   assign input_imag_2 = rd_data[2][WIDTH-1:0];
   assign input_imag_3 = rd_data[3][WIDTH-1:0];

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: N=16 instance for ordering/flow/reset, N=256 instance for the long ramp.
module tb_fft_input_loader;

   localparam int unsigned W = 16;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic         v16, rdy16, last16, fr16, en16, err16;
   logic [W-1:0] re16, im16;
   wire  [3:0][W-1:0] lre16, lim16;

   logic         v256, rdy256, last256, fr256, en256, err256;
   logic [W-1:0] re256, im256;
   wire  [3:0][W-1:0] lre256, lim256;

   fft_input_loader #(.WIDTH(16), .Num_of_samples(16)) u_dut16 (
      .clock(clock), .reset(reset), .s_valid(v16), .s_ready(rdy16),
      .s_real(re16), .s_imag(im16), .s_last(last16), .fft_ready(fr16),
      .input_en(en16),
      .input_real_0(lre16[0]), .input_real_1(lre16[1]), .input_real_2(lre16[2]), .input_real_3(lre16[3]),
      .input_imag_0(lim16[0]), .input_imag_1(lim16[1]), .input_imag_2(lim16[2]), .input_imag_3(lim16[3]),
      .frame_err(err16)
   );

   fft_input_loader #(.WIDTH(16), .Num_of_samples(256)) u_dut256 (
      .clock(clock), .reset(reset), .s_valid(v256), .s_ready(rdy256),
      .s_real(re256), .s_imag(im256), .s_last(last256), .fft_ready(fr256),
      .input_en(en256),
      .input_real_0(lre256[0]), .input_real_1(lre256[1]), .input_real_2(lre256[2]), .input_real_3(lre256[3]),
      .input_imag_0(lim256[0]), .input_imag_1(lim256[1]), .input_imag_2(lim256[2]), .input_imag_3(lim256[3]),
      .frame_err(err256)
   );

   typedef struct packed {
      logic [31:0]       cyc;
      logic [3:0][W-1:0] re;
      logic [3:0][W-1:0] im;
   } beat_t;

   beat_t q16[$];
   beat_t q256[$];

   // Capture every burst beat with the cycle it appeared in.
   always @(negedge clock) begin
      if (en16)  q16.push_back(beat_t'({32'(cyc), lre16, lim16}));
      if (en256) q256.push_back(beat_t'({32'(cyc), lre256, lim256}));
   end

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Digit reversal by repeated division, independent of the RTL helper.
   function automatic logic [15:0] rev_n(input int a, input int digits);
      int n;
      n = 0;
      for (int i = 0; i < digits; i++) begin
         n = n * 4 + a % 4;
         a = a / 4;
      end
      return 16'(n);
   endfunction

   task automatic send_frame16(input logic [15:0] base, input int last_pos, output int t_last);
      int waited;
      t_last = 0;
      for (int n = 0; n < 16; n++) begin
         v16    = 1'b1;
         re16   = base + 16'(n);
         im16   = ~(base + 16'(n));
         last16 = (n == last_pos);
         waited = 0;
         while (!rdy16 && waited < 100) begin
            tick();
            waited++;
         end
         if (!rdy16) check("accept16_wait", 64'(rdy16), 64'd1);
         t_last = cyc;
         tick();
      end
      v16    = 1'b0;
      last16 = 1'b0;
   endtask

   // N=16 burst c, lane k carries sample c+4k.
   task automatic check_burst16(input string tag, input int idx, input logic [15:0] base, input int t_first);
      logic [3:0][W-1:0] er, ei;
      if (q16.size() < idx + 4) begin
         check({tag, "_beats"}, 64'(q16.size()), 64'(idx + 4));
         return;
      end
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) begin
            er[k] = base + 16'(c + 4 * k);
            ei[k] = ~er[k];
         end
         check({tag, "_re"}, q16[idx + c].re, er);
         check({tag, "_im"}, q16[idx + c].im, ei);
         check({tag, "_cyc"}, 64'(q16[idx + c].cyc), 64'(t_first + c));
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_en"},  64'(en16),  64'd0);
      check({tag, "_re"},  lre16,      64'd0);
      check({tag, "_im"},  lim16,      64'd0);
      check({tag, "_rdy"}, 64'(rdy16), 64'd0);
      check({tag, "_err"}, 64'(err16), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, wt;
      logic [3:0][W-1:0] er, ei;

      reset = 1'b0;
      v16 = 1'b0; last16 = 1'b0; fr16 = 1'b1; re16 = '0; im16 = '0;
      v256 = 1'b0; last256 = 1'b0; fr256 = 1'b1; re256 = '0; im256 = '0;
      repeat (3) tick();
      check_reset_outs("rst");
      reset = 1'b1;
      tick();
      check("rel_rdy16", 64'(rdy16), 64'd1);
      check("rel_rdy256", 64'(rdy256), 64'd1);

      // Scenario 1: N=16 ramp, back-to-back
      q16.delete();
      send_frame16(16'h0000, 15, t);
      repeat (8) tick();
      check("t1_count", 64'(q16.size()), 64'd4);
      check_burst16("t1", 0, 16'h0000, t + 2);
      check("t1_err", 64'(err16), 64'd0);

      // Scenario 2: N=256 ramp, imag carries a sign-bit pattern
      q256.delete();
      t = 0;
      for (int n = 0; n < 256; n++) begin
         v256 = 1'b1; re256 = 16'(n); im256 = 16'h8000 | 16'(n); last256 = (n == 255);
         wt = 0;
         while (!rdy256 && wt < 100) begin
            tick();
            wt++;
         end
         if (!rdy256) check("accept256_wait", 64'(rdy256), 64'd1);
         t = cyc;
         tick();
      end
      v256 = 1'b0; last256 = 1'b0;
      repeat (70) tick();
      check("t2_count", 64'(q256.size()), 64'd64);
      if (q256.size() >= 64) begin
         er = {16'd192, 16'd128, 16'd64, 16'd0};
         check("t2_c0_re", q256[0].re, er);
         er = {16'd208, 16'd144, 16'd80, 16'd16};
         check("t2_c1_re", q256[1].re, er);
         for (int c = 0; c < 64; c++) begin
            for (int k = 0; k < 4; k++) begin
               er[k] = rev_n(4 * c + k, 4);
               ei[k] = 16'h8000 | er[k];
            end
            check("t2_re", q256[c].re, er);
            check("t2_im", q256[c].im, ei);
            check("t2_cyc", 64'(q256[c].cyc), 64'(t + 2 + c));
         end
      end
      check("t2_err", 64'(err256), 64'd0);

      // Scenario 3: downstream stalled while three frames are offered
      fr16 = 1'b0;
      q16.delete();
      send_frame16(16'h0100, 15, t);
      send_frame16(16'h0200, 15, t);
      check("t3_full_rdy", 64'(rdy16), 64'd0);
      v16 = 1'b1; re16 = 16'hdead; im16 = 16'hbeef; last16 = 1'b0;
      repeat (3) tick();
      check("t3_still_blocked", 64'(rdy16), 64'd0);
      check("t3_no_burst", 64'(q16.size()), 64'd0);
      v16 = 1'b0;
      wt = cyc;
      fr16 = 1'b1;
      repeat (14) tick();
      check("t3_count", 64'(q16.size()), 64'd8);
      check_burst16("t3a", 0, 16'h0100, wt + 2);
      check_burst16("t3b", 4, 16'h0200, wt + 7);
      check("t3_rdy_after", 64'(rdy16), 64'd1);

      // Scenario 4: fft_ready dropped after the burst has started
      q16.delete();
      send_frame16(16'h0300, 15, t);
      tick();
      fr16 = 1'b0;
      repeat (8) tick();
      check("t4_count", 64'(q16.size()), 64'd4);
      check_burst16("t4", 0, 16'h0300, t + 2);
      fr16 = 1'b1;

      // Scenario 5: early s_last, stickiness, missing s_last
      send_frame16(16'h0400, 10, t);
      repeat (8) tick();
      check("t5_err_early", 64'(err16), 64'd1);
      send_frame16(16'h0410, 15, t);
      repeat (8) tick();
      check("t5_sticky", 64'(err16), 64'd1);
      reset = 1'b0;
      tick();
      check("t5_rst_clears", 64'(err16), 64'd0);
      reset = 1'b1;
      tick();
      send_frame16(16'h0420, -1, t);
      repeat (8) tick();
      check("t5_err_missing", 64'(err16), 64'd1);

      // Scenario 6: reset mid-fill and mid-burst, then a clean replay
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      v16 = 1'b1; last16 = 1'b0;
      for (int n = 0; n < 8; n++) begin
         re16 = 16'h0500 + 16'(n);
         im16 = ~re16;
         tick();
      end
      v16 = 1'b0;
      reset = 1'b0;
      tick();
      check_reset_outs("t6_fill");
      reset = 1'b1;
      tick();
      check("t6_fill_rel_rdy", 64'(rdy16), 64'd1);

      q16.delete();
      send_frame16(16'h0600, 15, t);
      tick();
      tick();
      check("t6_in_burst", 64'(en16), 64'd1);
      reset = 1'b0;
      tick();
      check_reset_outs("t6_burst");
      reset = 1'b1;
      tick();

      q16.delete();
      send_frame16(16'h0000, 15, t);
      repeat (8) tick();
      check("t6_count", 64'(q16.size()), 64'd4);
      check_burst16("t6_replay", 0, 16'h0000, t + 2);
      check("t6_err", 64'(err16), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
